// File: rtl/scan_sequencer.sv
// scan_sequencer
// Round-robin channel scanner producing the 3-bit select for a 3-to-8 decoder.
// Each enabled channel in chan_mask is visited in ascending index order. A visit
// is an optional blanking gap of BLANK_CYCLES cycles, followed by a dwell of
// max(dwell,1) cycles.
//
// Every output is registered. Each output's next value comes from the same
// next-state decode that drives state_q, so the outputs line up exactly with
// the state they describe.
//
// Timing of en and chan_mask:
//   - en is sampled on each rising edge. If an edge sees en low, the block goes
//     to IDLE, and no step/wrap pulse is issued for the cycle after that edge.
//   - chan_mask is sampled on the edge that enters the final dwell cycle. This
//     sample decides step_pulse and wrap_pulse.
//   - chan_mask is sampled again on the edge that advances to the next channel.
//     This sample chooses the next channel, or goes to IDLE if the mask is empty.
//
// state_dbg exposes the FSM encoding (0=IDLE, 1=BLANK, 2=DWELL).

module scan_sequencer #(
    parameter int DWELL_W      = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         chan_mask,
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               blank,
    output logic               step_pulse,
    output logic               wrap_pulse,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DWELL = 2'd2
    } state_t;

    // The blank counter keeps at least one bit, so a zero-blank build still elaborates.
    localparam int BCW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [BCW-1:0] BLANK_LAST = BCW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic               sel_valid_q, sel_valid_d;
    logic               blank_q, blank_d;
    logic               step_q, step_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [BCW-1:0]     blank_cnt_q, blank_cnt_d;

    logic               enter_blank;
    logic               enter_dwell;
    logic [DWELL_W-1:0] dwell_load;
    logic               mask_any;
    logic [2:0]         nxt_of_sel_q;
    logic [2:0]         nxt_of_sel_d;
    logic [2:0]         start_chan;

    // Returns the first set mask bit searching c+1, c+2, ... and wrapping modulo 8.
    // The search ends at c itself, so a single-bit mask (or an empty one) returns c.
    function automatic logic [2:0] nxt_chan(input logic [2:0] c, input logic [7:0] m);
        logic [2:0] r;
        logic [2:0] idx;
        r = c;
        // Scan from the far end backwards so the nearest match is written last.
        for (int i = 8; i >= 1; i--) begin
            idx = c + 3'(i);
            if (m[idx]) begin
                r = idx;
            end
        end
        return r;
    endfunction

    // Returns the lowest set bit of the mask. An empty mask gives 0.
    function automatic logic [2:0] first_chan(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction

    // Combinational helpers: mask status, channel search, and the dwell reload value.
    always_comb begin
        mask_any     = |chan_mask;
        start_chan   = first_chan(chan_mask);
        nxt_of_sel_q = nxt_chan(sel_q, chan_mask);
        // A dwell of 0 behaves like 1, so the counter reloads with 0 in both cases.
        dwell_load   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    end

    // Next-state decode: FSM transitions, channel advance, and counter updates.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        dwell_cnt_d = dwell_cnt_q;
        blank_cnt_d = blank_cnt_q;
        enter_blank = 1'b0;
        enter_dwell = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en && mask_any) begin
                    sel_d = start_chan;
                    if (BLANK_CYCLES == 0) begin
                        enter_dwell = 1'b1;
                    end else begin
                        enter_blank = 1'b1;
                    end
                end
            end

            S_BLANK: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (blank_cnt_q == '0) begin
                    enter_dwell = 1'b1;
                end else begin
                    blank_cnt_d = blank_cnt_q - BCW'(1);
                end
            end

            S_DWELL: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (dwell_cnt_q == '0) begin
                    // Advance point. An empty mask ends the scan; sel keeps its value.
                    if (!mask_any) begin
                        state_d = S_IDLE;
                    end else begin
                        sel_d = nxt_of_sel_q;
                        if (BLANK_CYCLES == 0) begin
                            enter_dwell = 1'b1;
                        end else begin
                            enter_blank = 1'b1;
                        end
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_blank) begin
            state_d     = S_BLANK;
            blank_cnt_d = BLANK_LAST;
        end
        if (enter_dwell) begin
            // Sample dwell on entry; later changes take effect at the next channel.
            state_d     = S_DWELL;
            dwell_cnt_d = dwell_load;
        end
    end

    // Registered-output decode derived from the next state.
    always_comb begin
        nxt_of_sel_d = nxt_chan(sel_d, chan_mask);
        sel_valid_d  = (state_d == S_DWELL);
        blank_d      = (state_d == S_BLANK);
        // The pulse marks the final dwell cycle. It needs a non-empty mask, so
        // there is a channel to step to.
        step_d       = (state_d == S_DWELL) && (dwell_cnt_d == '0) && mask_any;
        wrap_d       = step_d && (nxt_of_sel_d <= sel_d);
    end

    // State, counter, and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sel_q       <= 3'd0;
            sel_valid_q <= 1'b0;
            blank_q     <= 1'b0;
            step_q      <= 1'b0;
            wrap_q      <= 1'b0;
            dwell_cnt_q <= '0;
            blank_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            blank_q     <= blank_d;
            step_q      <= step_d;
            wrap_q      <= wrap_d;
            dwell_cnt_q <= dwell_cnt_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    assign sel        = sel_q;
    assign sel_valid  = sel_valid_q;
    assign blank      = blank_q;
    assign step_pulse = step_q;
    assign wrap_pulse = wrap_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer (DWELL_W=16, BLANK_CYCLES=2).
// Inputs are driven on the falling edge and outputs are sampled on the falling
// edge. Each sample is compared as the packed vector
//   {sel[2:0], sel_valid, blank, step_pulse, wrap_pulse}.
// Sample k=0 is the first sample after the rising edge that sees en=1.

module tb_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] dwell = 16'd0;
    logic [7:0]  chan_mask = 8'd0;
    logic [2:0]  sel;
    logic        sel_valid;
    logic        blank;
    logic        step_pulse;
    logic        wrap_pulse;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    // Clock and reset.
    always #5 clk = ~clk;

    scan_sequencer #(.DWELL_W(16), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .dwell      (dwell),
        .chan_mask  (chan_mask),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .blank      (blank),
        .step_pulse (step_pulse),
        .wrap_pulse (wrap_pulse),
        .state_dbg  (state_dbg)
    );

    // Driver: synchronous-looking reset pulse used between scenarios.
    task automatic do_reset();
        en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [6:0] got;
        // Reset is held from time 0.
        @(negedge clk);
        got = {sel, sel_valid, blank, step_pulse, wrap_pulse};
        checks++;
        if (got !== 7'd0) begin
            errors++;
            $display("FAIL reset_init got=%b want=%b", got, 7'd0);
        end
        checks++;
        if (state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_init_state got=%0d want=0", state_dbg);
        end

        // Start a scan and get into the dwell of channel 0 (k=2).
        rst_n = 1'b1;
        chan_mask = 8'hFF;
        dwell = 16'd3;
        en = 1'b1;
        repeat (3) @(negedge clk);
        got = {sel, sel_valid, blank, step_pulse, wrap_pulse};
        checks++;
        if (got !== 7'b000_1_0_0_0) begin
            errors++;
            $display("FAIL reset_pre_dwell got=%b want=%b", got, 7'b000_1_0_0_0);
        end

        // Assert reset between clock edges; the outputs must clear with no edge.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        got = {sel, sel_valid, blank, step_pulse, wrap_pulse};
        checks++;
        if (got !== 7'd0) begin
            errors++;
            $display("FAIL reset_async got=%b want=%b", got, 7'd0);
        end
        checks++;
        if (state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_async_state got=%0d want=0", state_dbg);
        end

        // Release reset with en low: the block must remain idle.
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        got = {sel, sel_valid, blank, step_pulse, wrap_pulse};
        checks++;
        if (got !== 7'd0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_stay_idle got=%b/%0d want=%b/0", got, state_dbg, 7'd0);
        end
    endtask

    task automatic test_full_scan();
        logic [6:0] got;
        logic [6:0] want;
        int ch;
        int ph;
        int steps;
        int wraps;
        int overlap;
        do_reset();
        chan_mask = 8'hFF;
        dwell = 16'd3;
        en = 1'b1;
        steps = 0;
        wraps = 0;
        overlap = 0;
        // Each channel takes 5 cycles: 2 blank, then 3 dwell; step on the last dwell cycle.
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            ch = (k / 5) % 8;
            ph = k % 5;
            want = {3'(ch), (ph >= 2), (ph < 2), (ph == 4), (ph == 4) && (ch == 7)};
            got = {sel, sel_valid, blank, step_pulse, wrap_pulse};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL full_scan k=%0d got=%b want=%b", k, got, want);
            end
            if (step_pulse) steps++;
            if (wrap_pulse) wraps++;
            if (sel_valid && blank) overlap++;
        end
        checks++;
        if (steps !== 9) begin
            errors++;
            $display("FAIL full_scan_steps got=%0d want=9", steps);
        end
        checks++;
        if (wraps !== 1) begin
            errors++;
            $display("FAIL full_scan_wraps got=%0d want=1", wraps);
        end
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL full_scan_overlap got=%0d want=0", overlap);
        end
    endtask

    task automatic test_sparse();
        logic [6:0] got;
        logic [6:0] want;
        logic [2:0] seq [3];
        int ch;
        int ph;
        seq[0] = 3'd2;
        seq[1] = 3'd4;
        seq[2] = 3'd7;
        // A dwell of 1 and a dwell of 0 must give identical 3-cycle channel periods.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            chan_mask = 8'b1001_0100;
            dwell = (pass == 0) ? 16'd1 : 16'd0;
            en = 1'b1;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                ch = (k / 3) % 3;
                ph = k % 3;
                want = {seq[ch], (ph == 2), (ph < 2), (ph == 2), (ph == 2) && (ch == 2)};
                got = {sel, sel_valid, blank, step_pulse, wrap_pulse};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL sparse dwell=%0d k=%0d got=%b want=%b", dwell, k, got, want);
                end
            end
        end
    endtask

    task automatic test_single();
        logic [6:0] got;
        logic [6:0] want;
        int ph;
        do_reset();
        chan_mask = 8'h20;
        dwell = 16'd2;
        en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            ph = k % 4;
            want = {3'd5, (ph >= 2), (ph < 2), (ph == 3), (ph == 3)};
            got = {sel, sel_valid, blank, step_pulse, wrap_pulse};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL single k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    task automatic test_mask_change();
        logic [6:0] got;
        logic [6:0] want;
        do_reset();
        chan_mask = 8'hFF;
        dwell = 16'd3;
        en = 1'b1;
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            got = {sel, sel_valid, blank, step_pulse, wrap_pulse};
            want = 7'bx;
            case (k)
                17:      want = 7'b011_1_0_0_0;
                18:      want = 7'b011_1_0_0_0;
                19:      want = 7'b011_1_0_1_1;
                20, 21:  want = 7'b000_0_1_0_0;
                22, 23:  want = 7'b000_1_0_0_0;
                24:      want = 7'b000_1_0_1_1;
                25, 26, 27: want = 7'b000_0_0_0_0;
                default: want = 7'bx;
            endcase
            if (k >= 17) begin
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL mask_change k=%0d got=%b want=%b", k, got, want);
                end
            end
            // The mask narrows during channel 3's first dwell cycle.
            if (k == 17) chan_mask = 8'h01;
            // The mask empties during channel 0's step cycle, before the advance edge.
            if (k == 24) chan_mask = 8'h00;
        end
        checks++;
        if (state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL mask_change_idle got=%0d want=0", state_dbg);
        end
    endtask

    task automatic test_disable();
        logic [6:0] got;
        logic [6:0] want;
        int ph;
        do_reset();
        chan_mask = 8'hFF;
        dwell = 16'd3;
        en = 1'b1;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            got = {sel, sel_valid, blank, step_pulse, wrap_pulse};
            case (k)
                22, 23:  want = 7'b100_1_0_0_0;
                24, 25:  want = 7'b100_0_0_0_0;
                default: want = 7'bx;
            endcase
            if (k >= 22) begin
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL disable k=%0d got=%b want=%b", k, got, want);
                end
            end
            // en drops, so the edge that would begin channel 4's final dwell cycle sees it low.
            if (k == 23) en = 1'b0;
        end
        checks++;
        if (state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL disable_idle got=%0d want=0", state_dbg);
        end

        // Re-enabling restarts from the lowest enabled channel (4), beginning with a full blank period.
        chan_mask = 8'h30;
        en = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            ph = j;
            case (ph)
                0, 1:    want = 7'b100_0_1_0_0;
                2, 3:    want = 7'b100_1_0_0_0;
                4:       want = 7'b100_1_0_1_0;
                default: want = 7'b101_0_1_0_0;
            endcase
            got = {sel, sel_valid, blank, step_pulse, wrap_pulse};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reenable j=%0d got=%b want=%b", j, got, want);
            end
        end
    endtask

    // Sequence of scenarios and final report.
    initial begin
        test_reset();
        test_full_scan();
        test_sparse();
        test_single();
        test_mask_change();
        test_disable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
